// File: rtl/vx_tcu_imma_core_if.sv
// ----------------------------------------------------------------------------
// vx_tcu_imma_core_if
// Request/response bundle for the integer tensor-core MMA tile.
//   in_*      : request from TCU dispatch (valid/ready, header, format, sat,
//               element mask, packed A rows, B columns, C tile)
//   out_*     : result toward the TCU result arbiter (valid/ready, header, D)
// Modports:
//   master : the requester/consumer side (drives requests, accepts results)
//   slave  : the core side
// ----------------------------------------------------------------------------
interface vx_tcu_imma_core_if #(
    parameter int unsigned TC_M  = 2,
    parameter int unsigned TC_N  = 2,
    parameter int unsigned TC_K  = 2,
    parameter int unsigned HDR_W = 32
);
    logic                       in_valid;
    logic                       in_ready;
    logic [HDR_W-1:0]           in_header;
    logic [1:0]                 in_fmt;
    logic                       in_sat;
    logic [TC_K*8-1:0]          in_mask;
    logic [TC_M*TC_K*32-1:0]    in_a;
    logic [TC_N*TC_K*32-1:0]    in_b;
    logic [TC_M*TC_N*32-1:0]    in_c;
    logic                       out_valid;
    logic                       out_ready;
    logic [HDR_W-1:0]           out_header;
    logic [TC_M*TC_N*32-1:0]    out_d;

    modport master (
        output in_valid, in_header, in_fmt, in_sat, in_mask, in_a, in_b, in_c, out_ready,
        input  in_ready, out_valid, out_header, out_d
    );

    modport slave (
        input  in_valid, in_header, in_fmt, in_sat, in_mask, in_a, in_b, in_c, out_ready,
        output in_ready, out_valid, out_header, out_d
    );
endinterface

// File: rtl/vx_tcu_imma_core.sv
// ----------------------------------------------------------------------------
// vx_tcu_imma_core
// Integer matrix-multiply-accumulate tile: D = C + A*B for a TC_M x TC_N tile,
// dot products over TC_K packed 32-bit words (int8 / uint8 / int4 elements),
// per-element mask, optional int32 saturation. Stallable fixed-latency pipe:
// input register, then LATENCY data stages; result appears LATENCY+1 cycles
// after acceptance. Headers travel through a small FIFO alongside.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high
//   bus   : vx_tcu_imma_core_if.slave (request in, result out)
// ----------------------------------------------------------------------------
module vx_tcu_imma_core #(
    parameter int unsigned TC_M    = 2,
    parameter int unsigned TC_N    = 2,
    parameter int unsigned TC_K    = 2,
    parameter int unsigned LATENCY = 3,
    parameter int unsigned HDR_W   = 32
) (
    input logic                 clk,
    input logic                 reset,
    vx_tcu_imma_core_if.slave   bus
);
    localparam int unsigned D_W        = TC_M * TC_N * 32;
    localparam int unsigned FIFO_AW    = $clog2(LATENCY + 1);
    localparam int unsigned FIFO_DEPTH = 2 ** FIFO_AW;

    // ------------------------------------------------------------------
    // Element helpers
    // ------------------------------------------------------------------
    // Element e of a packed word, widened to 9-bit signed. In 8-bit modes
    // elements 4..7 do not exist and read as zero, which also makes the
    // upper mask bits of each word irrelevant.
    function automatic logic signed [8:0] f_elem(input logic [31:0] w, input int unsigned e,
                                                 input logic [1:0] fmt);
        logic [3:0]        nib;
        logic [7:0]        byt;
        logic signed [8:0] val;
        val = '0;
        nib = w[4*e +: 4];
        if (fmt == 2'd2) begin
            val = {{5{nib[3]}}, nib};
        end else if (e < 4) begin
            byt = w[8*e +: 8];
            val = (fmt == 2'd1) ? {1'b0, byt} : {byt[7], byt};
        end
        return val;
    endfunction

    // Masked dot product of one A row and one B column, 48-bit signed.
    function automatic logic signed [47:0] f_dot(input logic [TC_K*32-1:0] row,
                                                 input logic [TC_K*32-1:0] col,
                                                 input logic [1:0]         fmt,
                                                 input logic [TC_K*8-1:0]  mask);
        logic signed [47:0] acc;
        logic signed [17:0] prod;
        acc = '0;
        for (int unsigned k = 0; k < TC_K; k++) begin
            for (int unsigned e = 0; e < 8; e++) begin
                if (mask[k*8+e]) begin
                    prod = f_elem(row[k*32 +: 32], e, fmt) * f_elem(col[k*32 +: 32], e, fmt);
                    acc  = acc + {{30{prod[17]}}, prod};
                end
            end
        end
        return acc;
    endfunction

    // ------------------------------------------------------------------
    // Handshake and global enable
    // ------------------------------------------------------------------
    logic                 w_en;
    logic                 w_fire;
    logic                 w_pop;
    logic                 w_fifo_full;
    logic [LATENCY:0]     r_vld;

    assign w_en        = !r_vld[LATENCY] || bus.out_ready;
    assign w_fire      = bus.in_valid && bus.in_ready;
    assign w_pop       = r_vld[LATENCY] && bus.out_ready;
    assign bus.in_ready  = w_en && !w_fifo_full;
    assign bus.out_valid = r_vld[LATENCY];

    // ------------------------------------------------------------------
    // Input register stage
    // ------------------------------------------------------------------
    logic [1:0]               r_fmt;
    logic                     r_sat;
    logic [TC_K*8-1:0]        r_mask;
    logic [TC_M*TC_K*32-1:0]  r_a;
    logic [TC_N*TC_K*32-1:0]  r_b;
    logic [D_W-1:0]           r_c;

    always_ff @(posedge clk) begin
        if (w_fire) begin
            r_fmt  <= bus.in_fmt;
            r_sat  <= bus.in_sat;
            r_mask <= bus.in_mask;
            r_a    <= bus.in_a;
            r_b    <= bus.in_b;
            r_c    <= bus.in_c;
        end
    end

    // ------------------------------------------------------------------
    // Dot products, accumulate with C, optional saturation
    // ------------------------------------------------------------------
    logic [D_W-1:0] w_d0;

    for (genvar gi = 0; gi < TC_M; gi++) begin : g_row
        for (genvar gj = 0; gj < TC_N; gj++) begin : g_col
            logic signed [47:0] w_sum;
            logic [31:0]        w_c;
            logic [31:0]        w_res;

            assign w_c   = r_c[(gi*TC_N+gj)*32 +: 32];
            assign w_sum = {{16{w_c[31]}}, w_c}
                         + f_dot(r_a[gi*TC_K*32 +: TC_K*32], r_b[gj*TC_K*32 +: TC_K*32],
                                 r_fmt, r_mask);

            // Out of int32 range exactly when bits 47..31 are not all copies of the sign.
            always_comb begin
                w_res = w_sum[31:0];
                if (r_sat && (w_sum[47:31] != {17{w_sum[47]}})) begin
                    w_res = w_sum[47] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                end
            end

            assign w_d0[(gi*TC_N+gj)*32 +: 32] = w_res;
        end
    end

    // ------------------------------------------------------------------
    // Data pipeline: r_d[0] follows the input register, r_d[LATENCY-1] is out_d
    // ------------------------------------------------------------------
    logic [D_W-1:0] r_d [LATENCY];

    always_ff @(posedge clk) begin
        if (w_en) begin
            r_d[0] <= w_d0;
            for (int unsigned s = 1; s < LATENCY; s++) begin
                r_d[s] <= r_d[s-1];
            end
        end
    end

    assign bus.out_d = r_d[LATENCY-1];

    // Valid shift register: bit 0 is the input register, bit LATENCY the output.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld <= '0;
        end else if (w_en) begin
            r_vld <= {r_vld[LATENCY-1:0], w_fire};
        end
    end

    // ------------------------------------------------------------------
    // Header FIFO; depth covers every stage so it only fills if the pipe does
    // ------------------------------------------------------------------
    logic [HDR_W-1:0]   r_hdr_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;

    assign w_fifo_full    = (r_count == (FIFO_AW+1)'(FIFO_DEPTH));
    assign bus.out_header = r_hdr_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_fire) begin
            r_hdr_mem[r_wr_ptr] <= bus.in_header;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_fire) begin
                r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            end
            case ({w_fire, w_pop})
                2'b10:   r_count <= r_count + (FIFO_AW+1)'(1);
                2'b01:   r_count <= r_count - (FIFO_AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_vx_tcu_imma_core.sv
module tb_vx_tcu_imma_core;
    localparam int unsigned TC_M    = 2;
    localparam int unsigned TC_N    = 2;
    localparam int unsigned TC_K    = 2;
    localparam int unsigned LATENCY = 3;
    localparam int unsigned HDR_W   = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vx_tcu_imma_core_if #(.TC_M(TC_M), .TC_N(TC_N), .TC_K(TC_K), .HDR_W(HDR_W)) bus ();

    vx_tcu_imma_core #(
        .TC_M(TC_M), .TC_N(TC_N), .TC_K(TC_K), .LATENCY(LATENCY), .HDR_W(HDR_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0]  hdr;
        logic [127:0] d;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   track  = 1'b1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: every output handshake pops the oldest expectation.
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_output: got header %h, required no output", bus.out_header);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("out_header", 128'(bus.out_header), 128'(e.hdr));
                check("out_d", bus.out_d, e.d);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input logic [31:0] hdr, input logic [1:0] fmt, input logic sat,
                         input logic [15:0] mask, input logic [127:0] a, input logic [127:0] b,
                         input logic [127:0] c, input logic [127:0] d_exp);
        bit ok;
        ok = 1'b0;
        bus.in_header = hdr;
        bus.in_fmt    = fmt;
        bus.in_sat    = sat;
        bus.in_mask   = mask;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_c      = c;
        bus.in_valid  = 1'b1;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready 0 for 50 cycles, required 1 (hdr %h)", hdr);
        end else if (track) begin
            sb_q.push_back({hdr, d_exp});
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 100 && sb_q.size() != 0; n++) @(negedge clk);
        check("drain_pending", 128'(sb_q.size()), 128'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic measure_latency(input string name);
        int n;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (bus.out_valid) break;
        end
        check(name, 128'(n), 128'(LATENCY + 1));
    endtask

    // Basic vector: D00=54, D01=100+1, D10=200+9, D11=-5 unchanged.
    localparam logic [127:0] BA = {32'h0, 32'h0000_0003, 32'h0202_0202, 32'h0101_0101};
    localparam logic [127:0] BB = {32'h0, 32'h0000_0100, 32'h0404_0404, 32'h0303_0303};
    localparam logic [127:0] BC = {32'hFFFF_FFFB, 32'd200, 32'd100, 32'd10};
    localparam logic [127:0] BD = {32'hFFFF_FFFB, 32'd209, 32'd101, 32'd54};

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_header = '0;
        bus.in_fmt    = '0;
        bus.in_sat    = 1'b0;
        bus.in_mask   = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_c      = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state, out_ready low
        @(negedge clk);
        check("reset_out_valid", 128'(bus.out_valid), 128'(0));
        check("reset_in_ready", 128'(bus.in_ready), 128'(1));
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;

        // Basic int8 + latency
        issue(32'hA000_0001, 2'd0, 1'b0, 16'hFFFF, BA, BB, BC, BD);
        measure_latency("latency_basic");
        wait_drain();

        // Signedness: -1*2 vs 255*2; reserved fmt behaves as int8
        issue(32'hA000_0002, 2'd0, 1'b0, 16'hFFFF, {96'h0, 32'hFF}, {96'h0, 32'h02},
              {96'h0, 32'd1000}, {96'h0, 32'd998});
        issue(32'hA000_0003, 2'd1, 1'b0, 16'hFFFF, {96'h0, 32'hFF}, {96'h0, 32'h02},
              {96'h0, 32'd1000}, {96'h0, 32'd1510});
        issue(32'hA000_0004, 2'd3, 1'b0, 16'hFFFF, {96'h0, 32'hFF}, {96'h0, 32'h02},
              {96'h0, 32'd1000}, {96'h0, 32'd998});
        // int4: 7 * -8 per element in word 0; word 1 is 7 * 1 per element
        issue(32'hA000_0005, 2'd2, 1'b0, 16'h00FF, {64'h0, 32'h7777_7777, 32'h7777_7777},
              {64'h0, 32'h1111_1111, 32'h8888_8888}, 128'h0, {96'h0, 32'hFFFF_FE40});
        issue(32'hA000_0006, 2'd2, 1'b0, 16'h0001, {64'h0, 32'h7777_7777, 32'h7777_7777},
              {64'h0, 32'h1111_1111, 32'h8888_8888}, 128'h0, {96'h0, 32'hFFFF_FFC8});
        issue(32'hA000_0007, 2'd2, 1'b0, 16'hFF00, {64'h0, 32'h7777_7777, 32'h7777_7777},
              {64'h0, 32'h1111_1111, 32'h8888_8888}, 128'h0, {96'h0, 32'd56});
        // Upper mask bits ignored in 8-bit mode, live in int4 mode
        issue(32'hA000_0008, 2'd0, 1'b0, 16'h00F1, {96'h0, 32'h0101_0101},
              {96'h0, 32'h0101_0101}, {96'h0, 32'd5}, {96'h0, 32'd6});
        issue(32'hA000_0009, 2'd2, 1'b0, 16'h00F1, {96'h0, 32'h0101_0101},
              {96'h0, 32'h0101_0101}, {96'h0, 32'd5}, {96'h0, 32'd8});
        // Saturation, positive and negative
        issue(32'hA000_000A, 2'd0, 1'b1, 16'hFFFF, {96'h0, 32'h7F}, {96'h0, 32'h7F},
              {96'h0, 32'h7FFF_FFF0}, {96'h0, 32'h7FFF_FFFF});
        issue(32'hA000_000B, 2'd0, 1'b0, 16'hFFFF, {96'h0, 32'h7F}, {96'h0, 32'h7F},
              {96'h0, 32'h7FFF_FFF0}, {96'h0, 32'h8000_3EF1});
        issue(32'hA000_000C, 2'd0, 1'b1, 16'hFFFF, {96'h0, 32'h7F}, {96'h0, 32'h81},
              {96'h0, 32'h8000_0010}, {96'h0, 32'h8000_0000});
        issue(32'hA000_000D, 2'd0, 1'b0, 16'hFFFF, {96'h0, 32'h7F}, {96'h0, 32'h81},
              {96'h0, 32'h8000_0010}, {96'h0, 32'h7FFF_C10F});
        wait_drain();

        // Backpressure: 8 back-to-back requests, 5-cycle stall after the first result
        fork
            begin
                for (int n = 0; n < 8; n++) begin
                    issue(32'hC000_0000 + 32'(n), 2'd0, 1'b0, 16'hFFFF,
                          {96'h0, 32'(n + 1)}, {96'h0, 32'd3},
                          {32'(n), 64'h0, 32'(10 * n)}, {32'(n), 64'h0, 32'(13 * n + 3)});
                end
            end
            begin
                int n;
                n = 0;
                while (n < 50 && !bus.out_valid) begin
                    @(negedge clk);
                    n++;
                end
                check("bp_first_valid", 128'(bus.out_valid), 128'(1));
                @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("stall_in_ready", 128'(bus.in_ready), 128'(0));
                    check("stall_out_valid", 128'(bus.out_valid), 128'(1));
                    if (sb_q.size() != 0) begin
                        check("stall_out_header", 128'(bus.out_header), 128'(sb_q[0].hdr));
                        check("stall_out_d", bus.out_d, sb_q[0].d);
                    end else begin
                        check("stall_pending", 128'(sb_q.size()), 128'(1));
                    end
                    @(posedge clk);
                    #1;
                end
                bus.out_ready = 1'b1;
            end
        join
        wait_drain();
        repeat (8) @(negedge clk);
        check("idle_out_valid", 128'(bus.out_valid), 128'(0));
        @(posedge clk);
        #1;

        // Reset mid-flight: three requests discarded
        track = 1'b0;
        issue(32'hDEAD_0001, 2'd0, 1'b0, 16'hFFFF, BA, BB, BC, BD);
        issue(32'hDEAD_0002, 2'd0, 1'b0, 16'hFFFF, BA, BB, BC, BD);
        issue(32'hDEAD_0003, 2'd0, 1'b0, 16'hFFFF, BA, BB, BC, BD);
        track = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_in_ready", 128'(bus.in_ready), 128'(1));
        begin
            int seen;
            seen = 0;
            repeat (6) begin
                @(negedge clk);
                if (bus.out_valid) seen++;
            end
            check("flushed_no_valid", 128'(seen), 128'(0));
        end
        @(posedge clk);
        #1;
        issue(32'hB000_0001, 2'd0, 1'b0, 16'hFFFF, BA, BB, BC, BD);
        measure_latency("latency_after_reset");
        wait_drain();
        repeat (6) @(negedge clk);
        check("final_out_valid", 128'(bus.out_valid), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vx_tcu_imma_core.md
# vx_tcu_imma_core

Parametrised integer matrix-multiply-accumulate core for the tensor unit, the integer counterpart to the floating-point FEDP tile core. Each accepted request carries one A row-block, one B column-block and one C tile. It produces D = C + A·B for a TC_M×TC_N tile through a stallable fixed-latency pipeline. New capabilities: selectable packed element format (int8, uint8, int4), a per-element valid mask, and an optional int32 saturation mode. It sits between the TCU dispatch (execute side) and the TCU result arbiter.

## Interface
Parameters:
- TC_M, 2, tile rows
- TC_N, 2, tile columns
- TC_K, 2, 32-bit packed words per dot product
- LATENCY, 3, dot-product pipeline stages after the input register (≥1)
- HDR_W, 32, opaque header width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_header  in  HDR_W  opaque tag, returned unchanged
- in_fmt  in  2  0=int8 signed, 1=uint8, 2=int4 signed, 3=reserved (treated as 0)
- in_sat  in  1  1=saturate result to int32, 0=wrap
- in_mask  in  TC_K*8  per-element enable
- in_a  in  TC_M*TC_K*32  row i = words [i*TC_K +: TC_K]
- in_b  in  TC_N*TC_K*32  column j = words [j*TC_K +: TC_K]
- in_c  in  TC_M*TC_N*32  signed C[i][j] at word i*TC_N+j
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready
- out_header  out  HDR_W  header of the result
- out_d  out  TC_M*TC_N*32  D[i][j] at word i*TC_N+j

## Operation
- Element unpacking: 8-bit modes use 4 elements per word, element e at bits [8e+7:8e], e=0..3. int4 uses 8 elements per word, element e at bits [4e+3:4e], e=0..7. int8/int4 elements are sign-extended; uint8 elements are zero-extended. A and B share the format.
- Mask: element e of word k contributes only if in_mask[k*8+e] is set. In 8-bit modes, mask bits k*8+4..k*8+7 are ignored. Masked elements contribute 0.
- Sum: S[i][j] = sext(C[i][j]) + Σ_k Σ_e a·b, computed in 48-bit signed. This is exact for all parameter values up to TC_K=64.
- Result: in_sat=0 gives D = S[31:0]. in_sat=1 gives D = S clamped to [0x80000000, 0x7FFFFFFF].
- fmt, sat, mask, C, A and B are registered at acceptance and travel with the request. The header goes into a FIFO of depth 2^clog2(LATENCY+1), pushed on accept and popped on output handshake.
- Pipeline: a shift register of LATENCY+1 valid bits. The request enters the top stage on accept; out_valid = bottom bit.
- Global enable: en = !out_valid || out_ready. All data and valid stages advance only when en=1.
- in_ready = en && !hdr_fifo_full.

## Timing
- Reset: out_valid=0, valid pipe cleared, header FIFO empty. in_ready=1 in the first cycle after reset deasserts, with out_ready don't-care. out_d and out_header are undefined while out_valid=0.
- Latency: a request accepted in cycle t gives out_valid in cycle t+LATENCY+1 when there are no stalls.
- Throughput: one request per cycle while out_ready=1.
- Stall: out_valid && !out_ready freezes every stage and drops in_ready to 0. out_d and out_header hold stable until the handshake.
- Simultaneous accept and output handshake in one cycle is legal; FIFO push and pop in the same cycle leave occupancy unchanged.
- Ordering is strictly in order; the header always matches its data.
- Reset asserted mid-operation discards all in-flight requests. No output handshake occurs for them.
- in_valid may deassert without a handshake; no request is lost or duplicated.

## Test plan
- Basic int8, TC_K=2, mask all ones, sat=0, LATENCY=3. A row 0 words = 0x01010101, 0x02020202; B col 0 words = 0x03030303, 0x04040404; C[0][0]=10. Required: D[0][0] = 10 + 4·3 + 4·8 = 54. out_valid 4 cycles after accept, with the matching header.
- Signedness: A=0xFF (others 0), B=0x02. fmt=0 gives D=C−2. fmt=1 gives D=C+510.
- int4 mode: A word 0x77777777, B word 0x88888888 (7×−8 per element), mask 0x00FF, C=0. Required: D=−448. Same inputs with mask 0x0001 give D=−56.
- Saturation: C=0x7FFFFFF0, A=0x7F, B=0x7F (16129). sat=1 gives D=0x7FFFFFFF; sat=0 gives D=0x80003EF1.
- Backpressure: 8 back-to-back requests with out_ready held low for 5 cycles mid-stream. Required: in_ready=0 throughout the stall, out_d/out_header stable, all 8 results delivered in order with correct values, and no extra output.
- Reset mid-flight: accept 3 requests, assert reset for 1 cycle. Required: no out_valid for the flushed requests. A new request then emerges with its own header after LATENCY+1 cycles.
